// File: rtl/axi4_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_cmd_master
// Description : Single-outstanding AXI4-Lite master. It accepts one read or
//               write command, runs the bus transaction with a per-state wait
//               limit, and returns the response on a valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_cmd_master #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 6,
   parameter int TIMEOUT_CYCLES     = 255
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,
   // command channel
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   // response channel
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              rsp_timeout,
   // AXI4-Lite write address
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   // AXI4-Lite write data
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   // AXI4-Lite write response
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   // AXI4-Lite read address
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   // AXI4-Lite read data
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam logic [2:0]  c_st_idle    = 3'd0;
   localparam logic [2:0]  c_st_wr      = 3'd1;
   localparam logic [2:0]  c_st_wr_resp = 3'd2;
   localparam logic [2:0]  c_st_rd_addr = 3'd3;
   localparam logic [2:0]  c_st_rd_data = 3'd4;
   localparam logic [2:0]  c_st_rsp     = 3'd5;
   localparam logic [15:0] c_timeout    = 16'(TIMEOUT_CYCLES);

   logic [2:0]                        r_state;
   logic [2:0]                        w_state_nxt;
   logic [15:0]                       r_cnt;
   logic [15:0]                       w_cnt_inc;

   logic                              r_cmd_ready;
   logic                              r_awvalid;
   logic                              r_wvalid;
   logic                              r_bready;
   logic                              r_arvalid;
   logic                              r_rready;
   logic                              r_rsp_valid;
   logic                              r_rsp_timeout;
   logic [1:0]                        r_rsp_resp;
   logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
   logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;

   logic                              w_cmd_ready_nxt;
   logic                              w_awvalid_nxt;
   logic                              w_wvalid_nxt;
   logic                              w_bready_nxt;
   logic                              w_arvalid_nxt;
   logic                              w_rready_nxt;
   logic                              w_rsp_valid_nxt;

   logic                              w_accept;
   logic                              w_aw_ok;
   logic                              w_w_ok;
   logic                              w_b_hs;
   logic                              w_ar_hs;
   logic                              w_r_hs;
   logic                              w_in_bus;
   logic                              w_timeout;

   // Handshake and wait-limit decodes. A channel counts as done once its
   // VALID has dropped (earlier handshake) or is handshaking right now.
   assign w_accept  = cmd_valid & r_cmd_ready;
   assign w_aw_ok   = ~r_awvalid | M_AXI_AWREADY;
   assign w_w_ok    = ~r_wvalid | M_AXI_WREADY;
   assign w_b_hs    = r_bready & M_AXI_BVALID;
   assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
   assign w_r_hs    = r_rready & M_AXI_RVALID;
   assign w_in_bus  = (r_state == c_st_wr) | (r_state == c_st_wr_resp) |
                      (r_state == c_st_rd_addr) | (r_state == c_st_rd_data);
   // The limit is hit when this cycle's increment would bring the counter
   // to TIMEOUT_CYCLES, so a bus state waits exactly TIMEOUT_CYCLES cycles.
   assign w_cnt_inc = r_cnt + 16'd1;
   assign w_timeout = (w_cnt_inc == c_timeout);

   // State register
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a handshake always beats the wait limit
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_accept) begin
               w_state_nxt = cmd_write ? c_st_wr : c_st_rd_addr;
            end
         end
         c_st_wr: begin
            if (w_aw_ok && w_w_ok) begin
               w_state_nxt = c_st_wr_resp;
            end else if (w_timeout) begin
               w_state_nxt = c_st_rsp;
            end
         end
         c_st_wr_resp: begin
            if (w_b_hs || w_timeout) begin
               w_state_nxt = c_st_rsp;
            end
         end
         c_st_rd_addr: begin
            if (w_ar_hs) begin
               w_state_nxt = c_st_rd_data;
            end else if (w_timeout) begin
               w_state_nxt = c_st_rsp;
            end
         end
         c_st_rd_data: begin
            if (w_r_hs || w_timeout) begin
               w_state_nxt = c_st_rsp;
            end
         end
         c_st_rsp: begin
            if (rsp_ready) begin
               w_state_nxt = c_st_idle;
            end
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   // Next values of the registered handshake outputs, decoded from the next state
   always_comb begin
      w_cmd_ready_nxt = (w_state_nxt == c_st_idle);
      w_bready_nxt    = (w_state_nxt == c_st_wr_resp);
      w_arvalid_nxt   = (w_state_nxt == c_st_rd_addr);
      w_rready_nxt    = (w_state_nxt == c_st_rd_data);
      w_rsp_valid_nxt = (w_state_nxt == c_st_rsp);
      w_awvalid_nxt   = 1'b0;
      w_wvalid_nxt    = 1'b0;
      if (r_state == c_st_idle) begin
         w_awvalid_nxt = (w_state_nxt == c_st_wr);
         w_wvalid_nxt  = (w_state_nxt == c_st_wr);
      end else if (r_state == c_st_wr && w_state_nxt == c_st_wr) begin
         w_awvalid_nxt = r_awvalid & ~M_AXI_AWREADY;
         w_wvalid_nxt  = r_wvalid & ~M_AXI_WREADY;
      end
   end

   // Output registers for all handshake signals
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_cmd_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_cmd_ready <= w_cmd_ready_nxt;
         r_awvalid   <= w_awvalid_nxt;
         r_wvalid    <= w_wvalid_nxt;
         r_bready    <= w_bready_nxt;
         r_arvalid   <= w_arvalid_nxt;
         r_rready    <= w_rready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
      end
   end

   // Wait counter: cleared on any state change, counts while in a bus state
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_cnt <= 16'd0;
      end else if (w_state_nxt != r_state) begin
         r_cnt <= 16'd0;
      end else if (w_in_bus) begin
         r_cnt <= w_cnt_inc;
      end
   end

   // Command latch; held stable for the whole transaction
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else if (w_accept) begin
         r_addr  <= cmd_addr;
         r_wdata <= cmd_wdata;
         r_wstrb <= cmd_wstrb;
      end
   end

   // Response capture; any other entry into RSP from a bus state is an abort
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_rsp_resp    <= 2'b00;
         r_rsp_rdata   <= '0;
         r_rsp_timeout <= 1'b0;
      end else if (r_state == c_st_wr_resp && w_b_hs) begin
         r_rsp_resp    <= M_AXI_BRESP;
         r_rsp_rdata   <= '0;
         r_rsp_timeout <= 1'b0;
      end else if (r_state == c_st_rd_data && w_r_hs) begin
         r_rsp_resp    <= M_AXI_RRESP;
         r_rsp_rdata   <= M_AXI_RDATA;
         r_rsp_timeout <= 1'b0;
      end else if (r_state != c_st_rsp && w_state_nxt == c_st_rsp) begin
         r_rsp_resp    <= 2'b11;
         r_rsp_rdata   <= '0;
         r_rsp_timeout <= 1'b1;
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign rsp_timeout   = r_rsp_timeout;
   assign M_AXI_AWADDR  = r_addr;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = r_wstrb;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_cmd_master
// Description : Directed self-checking bench for axi4_lite_cmd_master with a
//               16-register AXI4-Lite slave model and adjustable ready delays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_cmd_master;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;

   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [5:0]  cmd_addr  = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;

   logic [5:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [5:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   axi4_lite_cmd_master #(
      .C_M_AXI_DATA_WIDTH (32),
      .C_M_AXI_ADDR_WIDTH (6),
      .TIMEOUT_CYCLES     (16)
   ) u_dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_wstrb     (cmd_wstrb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .rsp_timeout   (rsp_timeout),
      .M_AXI_AWADDR  (awaddr),
      .M_AXI_AWPROT  (awprot),
      .M_AXI_AWVALID (awvalid),
      .M_AXI_AWREADY (awready),
      .M_AXI_WDATA   (wdata),
      .M_AXI_WSTRB   (wstrb),
      .M_AXI_WVALID  (wvalid),
      .M_AXI_WREADY  (wready),
      .M_AXI_BRESP   (bresp),
      .M_AXI_BVALID  (bvalid),
      .M_AXI_BREADY  (bready),
      .M_AXI_ARADDR  (araddr),
      .M_AXI_ARPROT  (arprot),
      .M_AXI_ARVALID (arvalid),
      .M_AXI_ARREADY (arready),
      .M_AXI_RDATA   (rdata),
      .M_AXI_RRESP   (rresp),
      .M_AXI_RVALID  (rvalid),
      .M_AXI_RREADY  (rready)
   );

   // ---------------- slave model: 16 x 32-bit registers ----------------
   logic [31:0] r_regs [16];
   int          aw_delay = 0;
   int          w_delay  = 0;
   int          ar_delay = 0;
   bit          ar_never = 1'b0;
   int          aw_cnt;
   int          w_cnt;
   int          ar_cnt;
   logic        aw_got;
   logic        w_got;
   logic [5:0]  aw_a;
   logic [31:0] w_d;
   logic [3:0]  w_s;
   int          b_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
         bvalid  <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00;
         rdata   <= '0;   aw_got <= 1'b0; w_got <= 1'b0;
         aw_cnt  <= 0;    w_cnt  <= 0;    ar_cnt <= 0;
         aw_a    <= '0;   w_d    <= '0;   w_s    <= '0;
      end else begin
         if (awready && awvalid) begin
            awready <= 1'b0; aw_got <= 1'b1; aw_a <= awaddr; aw_cnt <= 0;
         end else if (awvalid && !aw_got && !awready) begin
            if (aw_cnt >= aw_delay) awready <= 1'b1;
            else                    aw_cnt  <= aw_cnt + 1;
         end else if (!awvalid) begin
            awready <= 1'b0; aw_cnt <= 0;
         end
         if (wready && wvalid) begin
            wready <= 1'b0; w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; w_cnt <= 0;
         end else if (wvalid && !w_got && !wready) begin
            if (w_cnt >= w_delay) wready <= 1'b1;
            else                  w_cnt  <= w_cnt + 1;
         end else if (!wvalid) begin
            wready <= 1'b0; w_cnt <= 0;
         end
         if (aw_got && w_got && !bvalid) begin
            for (int b = 0; b < 4; b++) begin
               if (w_s[b]) r_regs[aw_a[5:2]][8*b +: 8] <= w_d[8*b +: 8];
            end
            bvalid <= 1'b1; bresp <= 2'b00; aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (arready && arvalid) begin
            arready <= 1'b0; rvalid <= 1'b1; rdata <= r_regs[araddr[5:2]];
            rresp <= 2'b00; ar_cnt <= 0;
         end else if (arvalid && !arready && !rvalid) begin
            if (!ar_never) begin
               if (ar_cnt >= ar_delay) arready <= 1'b1;
               else                    ar_cnt  <= ar_cnt + 1;
            end
         end else if (!arvalid) begin
            arready <= 1'b0; ar_cnt <= 0;
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   // Count completed write-response handshakes
   always @(posedge clk) begin
      if (bvalid && bready) b_cnt <= b_cnt + 1;
   end

   // ---------------- checking and stimulus helpers ----------------
   task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Offer a command and return at the falling edge after it was accepted
   task automatic send_cmd(input logic wr, input logic [5:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      int k;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) chk_value("cmd_accept_wait", 32'd0, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int k;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) chk_value("rsp_wait", 32'd0, 32'd1);
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit aw_first;
      bit stable;
      bit seen;
      int b0;
      int n;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk_value("rst_valids", {25'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 32'd0);
      chk_value("rst_rsp", {27'd0, rsp_timeout, rsp_resp, 2'b00}, 32'd0);
      chk_value("rst_addr_data", {20'd0, awaddr, araddr} | wdata | {28'd0, wstrb} | rsp_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_value("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

      // ---- full-word write ----
      send_cmd(1'b1, 6'h08, 32'hDEADBEEF, 4'hF);
      chk_value("wr_valids", {30'd0, awvalid, wvalid}, 32'd3);
      chk_value("wr_awaddr", {26'd0, awaddr}, 32'h08);
      chk_value("wr_wdata", wdata, 32'hDEADBEEF);
      chk_value("wr_wstrb_prot", {25'd0, wstrb, awprot}, {25'd0, 4'hF, 3'b000});
      chk_value("wr_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      wait_rsp();
      chk_value("wr_rsp", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
      chk_value("wr_rsp_rdata", rsp_rdata, 32'd0);
      release_rsp();
      chk_value("wr_back_idle", {30'd0, rsp_valid, cmd_ready}, 32'd1);

      // ---- read back ----
      send_cmd(1'b0, 6'h08, 32'd0, 4'h0);
      chk_value("rd_arvalid", {29'd0, arvalid, awvalid, wvalid}, 32'd4);
      chk_value("rd_araddr_prot", {23'd0, araddr, arprot}, {23'd0, 6'h08, 3'b000});
      wait_rsp();
      chk_value("rd_rdata", rsp_rdata, 32'hDEADBEEF);
      chk_value("rd_rsp", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
      release_rsp();

      // ---- byte-lane write then read ----
      send_cmd(1'b1, 6'h08, 32'h000000AA, 4'h1);
      wait_rsp();
      chk_value("strb_wr_rsp", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
      release_rsp();
      send_cmd(1'b0, 6'h08, 32'd0, 4'h0);
      wait_rsp();
      chk_value("strb_rd_rdata", rsp_rdata, 32'hDEADBEAA);
      release_rsp();

      // ---- AWREADY three cycles ahead of WREADY ----
      aw_delay = 0; w_delay = 3; b0 = b_cnt;
      send_cmd(1'b1, 6'h0C, 32'h12345678, 4'hF);
      aw_first = 1'b0; stable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid === 1'b1) break;
         if (!awvalid && wvalid) aw_first = 1'b1;
         if (wvalid && (wdata !== 32'h12345678 || wstrb !== 4'hF)) stable = 1'b0;
         if (awvalid && awaddr !== 6'h0C) stable = 1'b0;
         @(negedge clk);
      end
      wait_rsp();
      chk_value("split_aw_first", {31'd0, aw_first}, 32'd1);
      chk_value("split_stable", {31'd0, stable}, 32'd1);
      chk_value("split_rsp", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
      release_rsp();
      repeat (3) @(negedge clk);
      chk_value("split_b_count", 32'(b_cnt - b0), 32'd1);
      w_delay = 0;

      // ---- response back-pressure ----
      send_cmd(1'b0, 6'h08, 32'd0, 4'h0);
      wait_rsp();
      stable = 1'b1;
      repeat (10) begin
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEAA || cmd_ready !== 1'b0) stable = 1'b0;
         @(negedge clk);
      end
      chk_value("bp_stable", {31'd0, stable}, 32'd1);
      release_rsp();
      chk_value("bp_release_idle", {30'd0, rsp_valid, cmd_ready}, 32'd1);

      // ---- ARREADY never comes: abort after 16 waiting cycles ----
      ar_never = 1'b1;
      send_cmd(1'b0, 6'h10, 32'd0, 4'h0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid === 1'b1) break;
         if (arvalid) n++;
         @(negedge clk);
      end
      wait_rsp();
      chk_value("tmo_arvalid_cycles", 32'(n), 32'd16);
      chk_value("tmo_rsp", {29'd0, rsp_timeout, rsp_resp}, 32'd7);
      chk_value("tmo_rdata", rsp_rdata, 32'd0);
      chk_value("tmo_valids_low", {30'd0, arvalid, rready}, 32'd0);
      release_rsp();
      ar_never = 1'b0;
      send_cmd(1'b0, 6'h08, 32'd0, 4'h0);
      wait_rsp();
      chk_value("post_tmo_rdata", rsp_rdata, 32'hDEADBEAA);
      chk_value("post_tmo_rsp", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
      release_rsp();

      // ---- reset while WVALID pending ----
      w_delay = 10;
      send_cmd(1'b1, 6'h14, 32'hCAFEF00D, 4'hF);
      repeat (2) @(negedge clk);
      chk_value("mid_wvalid_pending", {31'd0, wvalid}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_value("mid_rst_async", {25'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      w_delay = 0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk_value("mid_no_rsp", {31'd0, seen}, 32'd0);
      chk_value("mid_idle_ready", {31'd0, cmd_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi4_lite_cmd_master.md
AXI4_LITE_CMD_MASTER -- requirements
Module: axi4_lite_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, bus data width (32 only).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 6, bus address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles a bus state may wait before abort (1..65535).
REQ-004 SHALL have one clock; reset is asynchronous and active-low; the ports are M_AXI_ACLK (input, 1, clock) and M_AXI_ARESETN (input, 1, reset).
REQ-005 SHALL have cmd_valid in 1 (command offered), cmd_ready out 1 (command accepted), cmd_write in 1 (1 = write, 0 = read).
REQ-006 SHALL have cmd_addr in ADDR_WIDTH, cmd_wdata in DATA_WIDTH, cmd_wstrb in DATA_WIDTH/8.
REQ-007 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_rdata out DATA_WIDTH, rsp_resp out 2, rsp_timeout out 1.
REQ-008 SHALL have AXI4-Lite master ports: M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY, with standard directions and widths.

Function
REQ-009 SHALL implement FSM states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; the command is accepted on cmd_valid&&cmd_ready, and cmd_addr/wdata/wstrb/write SHALL be latched in that cycle.
REQ-011 SHALL go IDLE->WR on an accepted write, and assert AWVALID and WVALID together in the next cycle.
REQ-012 SHALL hold AWVALID until AWVALID&&AWREADY, and hold WVALID independently until WVALID&&WREADY; AWADDR/WDATA/WSTRB SHALL remain stable while the matching VALID is high.
REQ-013 SHALL go WR->WR_RESP in the cycle after both handshakes complete, whether they occur in the same or different cycles.
REQ-014 SHALL assert BREADY=1 only in WR_RESP; on BVALID, it SHALL capture BRESP into rsp_resp, set rsp_rdata=0 and go to RSP.
REQ-015 SHALL go IDLE->RD_ADDR on an accepted read, with ARVALID held until ARREADY and then a move to RD_DATA.
REQ-016 SHALL assert RREADY=1 only in RD_DATA; on RVALID, it SHALL capture RDATA/RRESP and go to RSP.
REQ-017 SHALL drive AWPROT=ARPROT=3'b000; address bits SHALL be passed unmodified, with no alignment forced.
REQ-018 SHALL hold rsp_valid=1 in RSP, with rsp_* stable until rsp_ready, then go RSP->IDLE; the earliest next cmd_ready is the following cycle.
REQ-019 SHALL run a 16-bit wait counter that clears on every state change and increments each cycle in WR, WR_RESP, RD_ADDR or RD_DATA.
REQ-020 SHALL, when the counter reaches TIMEOUT_CYCLES, deassert all VALID/READY outputs next cycle and go to RSP with rsp_timeout=1, rsp_resp=2'b11 and rsp_rdata=0. This is the only permitted VALID withdrawal before handshake.
REQ-021 SHALL give a handshake in the same cycle as the counter reaching TIMEOUT_CYCLES priority; the transaction then completes normally with rsp_timeout=0.
REQ-022 SHALL drive rsp_timeout=0 for all non-timeout responses.
REQ-023 SHALL allow at most one outstanding transaction; cmd_valid outside IDLE SHALL be ignored with no buffering.
REQ-024 SHALL register all AXI and handshake outputs, with no combinational path from any input to any output.

Reset
REQ-025 SHALL, while M_AXI_ARESETN=0 (asynchronously), force state IDLE and counter 0, and drive all AXI VALID/READY outputs, rsp_valid, rsp_timeout and rsp_resp to 0. cmd_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion.
REQ-026 SHALL reset AWADDR, ARADDR, WDATA, WSTRB and rsp_rdata to 0.
REQ-027 SHALL, on reset mid-transaction, abandon the transaction with no response produced; rsp_valid SHALL stay 0 until a new command completes.

Verification
REQ-028 SHALL cover: write addr 0x08, data 0xDEADBEEF, wstrb 0xF to the team's register slave (16 regs) -> rsp OKAY, timeout 0; a following read of 0x08 -> rsp_rdata 0xDEADBEEF, rsp_resp 00.
REQ-029 SHALL cover: write 0x000000AA wstrb 0x1 over register 0x08 holding 0xDEADBEEF -> read returns 0xDEADBEAA.
REQ-030 SHALL cover: a slave model with AWREADY 3 cycles before WREADY -> AWVALID drops first, WVALID holds, and exactly one B handshake occurs.
REQ-031 SHALL cover: rsp_ready held low 10 cycles after a read -> rsp_valid and rsp_rdata stable throughout and cmd_ready 0; release -> IDLE next cycle.
REQ-032 SHALL cover: a slave that never asserts ARREADY, with TIMEOUT_CYCLES=16 -> ARVALID drops after 16 waiting cycles, then rsp_timeout=1 and rsp_resp=11, and a subsequent command is accepted.
REQ-033 SHALL cover: reset asserted while WVALID is pending -> all VALID outputs 0 immediately (asynchronous) and no rsp_valid after release.
